// File: rtl/spi_mem_scheduler_pkg.sv
// Shared definitions for the SPI EEPROM command scheduler.
//   state_t  : scheduler FSM states
//   CMD_*    : bit positions inside the 32-bit command / result word
//   mk_cmd() : builds the command word that starts one byte transfer
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_GUARD
    } state_t;

    localparam int CMD_READY    = 31;
    localparam int CMD_BUSY     = 30;
    localparam int CMD_RWN      = 29;
    localparam int CMD_DATA_LSB = 7;
    localparam int CMD_ADDR_W   = 7;

    // Busy set, R/Wn from the request; the data field is only meaningful
    // for writes, so reads carry zero there.
    function automatic logic [31:0] mk_cmd(input logic                  we,
                                           input logic [CMD_ADDR_W-1:0] addr,
                                           input logic [7:0]            wdata);
        logic [31:0] cmd;
        cmd                       = '0;
        cmd[CMD_BUSY]             = 1'b1;
        cmd[CMD_RWN]              = ~we;
        if (we)
            cmd[CMD_DATA_LSB +: 8] = wdata;
        cmd[CMD_ADDR_W-1:0]       = addr;
        return cmd;
    endfunction

endpackage

// File: rtl/spi_mem_scheduler_if.sv
// Bundle of the requester-side and SPI-master-side signals of the scheduler.
//   req_valid/req_we/req_addr/req_wdata : requests, NREQ lanes (7/8 bits each)
//   req_ready                           : one-cycle accept pulse per lane
//   rsp_valid/rsp_err/rsp_rdata         : completion pulse, error, read byte
//   cmd_word                            : command word to the SPI master
//   res_word/res_we                     : result word and its write strobe
// Modport slave is the scheduler view, master is the surrounding logic.
interface spi_mem_scheduler_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_we;
    logic [NREQ*7-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic              rsp_err;
    logic [7:0]        rsp_rdata;
    logic [31:0]       cmd_word;
    logic [31:0]       res_word;
    logic              res_we;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, res_word, res_we,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, cmd_word
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, res_word, res_we,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, cmd_word
    );
endinterface

// File: rtl/spi_mem_scheduler_rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector
//   last_grant : index granted most recently; the search starts one above it
//   grant      : one-hot winner (zero when no request)
//   grant_idx  : winner index
//   any        : at least one request present
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);
    always_comb begin
        int cand;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        // Offsets 1..NREQ visit every lane once, ending on last_grant itself.
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(last_grant) + off) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end
endmodule

// File: rtl/spi_mem_scheduler.sv
// Shares one SPI EEPROM master between NREQ requesters. One granted request
// at a time: issue a command word, wait for the master's result, answer the
// requester, then keep busy low for GUARD cycles before the next command.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester and master signals (spi_mem_scheduler_if.slave)
// NREQ must match the NREQ of the connected interface instance.
module spi_mem_scheduler
    import spi_mem_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 8192,
    parameter int GUARD   = 4
) (
    input logic                clk,
    input logic                rst_n,
    spi_mem_scheduler_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GD_W  = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [GD_W-1:0] GD_LAST = GD_W'(GUARD - 1);

    state_t                  state, state_next;
    logic [IDX_W-1:0]        last_grant, winner;
    logic                    we_q;
    logic [CMD_ADDR_W-1:0]   addr_q;
    logic                    seen_we;
    logic [TO_W-1:0]         to_cnt;
    logic [GD_W-1:0]         gd_cnt;

    logic [NREQ-1:0]         grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    sel_we;
    logic [CMD_ADDR_W-1:0]   sel_addr;
    logic [7:0]              sel_wdata;
    logic                    done, timed_out, mismatch, finish;

    logic [31:0]             cmd_q, cmd_d;
    logic [NREQ-1:0]         req_ready_q, req_ready_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [7:0]              rsp_rdata_q, rsp_rdata_d;
    logic                    unused_res_bits;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant_oh),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    assign sel_we    = bus.req_we[grant_idx];
    assign sel_addr  = bus.req_addr[int'(grant_idx)*CMD_ADDR_W +: CMD_ADDR_W];
    assign sel_wdata = bus.req_wdata[int'(grant_idx)*8 +: 8];

    // The master rewrites its result word only after dropping the strobe,
    // so the strobe must already have been seen and must now be low.
    assign done      = seen_we && !bus.res_we && bus.res_word[CMD_READY];
    assign timed_out = (to_cnt == TO_LAST);
    assign mismatch  = (bus.res_word[CMD_ADDR_W-1:0] != addr_q);
    assign finish    = done || timed_out;

    assign unused_res_bits = ^bus.res_word[30:15];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (grant_any) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (finish) state_next = ST_RESP;
            ST_RESP:  state_next = ST_GUARD;
            ST_GUARD: if (gd_cnt == GD_LAST) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Control state: grant pointer, strobe tracking, counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IDX_W'(NREQ - 1);
            winner     <= '0;
            seen_we    <= 1'b0;
            to_cnt     <= '0;
            gd_cnt     <= '0;
        end else begin
            unique case (state)
                ST_IDLE:  if (grant_any) winner <= grant_idx;
                ST_ISSUE: begin
                    last_grant <= winner;
                    seen_we    <= 1'b0;
                    to_cnt     <= '0;
                end
                ST_WAIT: begin
                    if (bus.res_we)
                        seen_we <= 1'b1;
                    if (to_cnt != TO_LAST)
                        to_cnt <= to_cnt + TO_W'(1);
                end
                ST_RESP:  gd_cnt <= '0;
                ST_GUARD: gd_cnt <= gd_cnt + GD_W'(1);
                default: ;
            endcase
        end
    end

    // Request payload latched at grant time; needs no reset
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && grant_any) begin
            we_q   <= sel_we;
            addr_q <= sel_addr;
        end
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        cmd_d       = '0;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        unique case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    cmd_d       = mk_cmd(sel_we, sel_addr, sel_wdata);
                    req_ready_d = grant_oh;
                end
            end
            ST_ISSUE: cmd_d = cmd_q;
            ST_WAIT: begin
                if (finish) begin
                    rsp_valid_d = NREQ'(1) << winner;
                    rsp_err_d   = !done || mismatch;
                    if (done && !mismatch && !we_q)
                        rsp_rdata_d = bus.res_word[CMD_DATA_LSB +: 8];
                end else begin
                    cmd_d = cmd_q;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cmd_q       <= cmd_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_word  = cmd_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_mem_scheduler.sv
// Bench for spi_mem_scheduler: a behavioural EEPROM/master model answers
// commands, a driver posts requests and queues expected grants/responses,
// and a monitor compares everything the scheduler presents.
module tb_spi_mem_scheduler;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int GUARD   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_mem_scheduler_if #(.NREQ(NREQ)) bus();

    spi_mem_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          idx;
        logic [31:0] cmd;
    } iss_t;

    typedef struct {
        int         idx;
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } rsp_t;

    iss_t       exp_iss[$];
    rsp_t       exp_rsp[$];
    logic [7:0] eeprom[128];
    logic [7:0] ref_mem[128];
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         cyc        = 0;
    int         fault_mode = 0;  // 0 normal, 1 wrong result address, 2 silent master
    int         lg_model   = NREQ - 1;
    int         n_rsp_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    function automatic logic [31:0] exp_cmd(input logic we, input logic [6:0] a, input logic [7:0] d);
        logic [31:0] c;
        c = 32'h4000_0000 | {25'b0, a};
        if (we) c = c | {17'b0, d, 7'b0};
        else    c = c | 32'h2000_0000;
        return c;
    endfunction

    function automatic int pick(input bit [NREQ-1:0] pend, input int lg);
        for (int off = 1; off <= NREQ; off++)
            if (pend[(lg + off) % NREQ]) return (lg + off) % NREQ;
        return -1;
    endfunction

    // ---------------- EEPROM / SPI master model ----------------
    initial begin
        logic [31:0] c;
        logic [6:0]  a;
        logic [7:0]  d;
        int          mode;
        for (int i = 0; i < 128; i++) eeprom[i] = 8'(i * 29 + 7);
        bus.res_we   = 1'b0;
        bus.res_word = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.cmd_word[30]) begin
                c    = bus.cmd_word;
                mode = fault_mode;
                a    = c[6:0];
                bus.res_word[31] = 1'b0;
                if (mode != 2) begin
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    bus.res_we = 1'b1;
                    repeat (2) @(negedge clk);
                    bus.res_we = 1'b0;
                    if (c[29]) d = eeprom[a];
                    else begin
                        d = c[14:7];
                        eeprom[a] = d;
                    end
                    bus.res_word = {1'b1, 16'h0, d, (mode == 1) ? (a ^ 7'h01) : a};
                end
                for (int t = 0; t < TIMEOUT + 20 && bus.cmd_word[30]; t++) @(negedge clk);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int          issue_cyc    = 0;
    int          last_rsp_cyc = 0;
    bit          have_rsp     = 0;
    logic [31:0] last_cmd     = '0;

    always @(negedge clk) begin : mon
        iss_t ei;
        rsp_t er;
        if (!rst_n) begin
            have_rsp = 0;
        end else begin
            if (bus.req_ready != '0) begin
                if (exp_iss.size() == 0) begin
                    fail_now("unexpected_ready", $sformatf("req_ready=%b with no pending grant", bus.req_ready));
                end else begin
                    ei = exp_iss.pop_front();
                    check("grant", 32'(bus.req_ready), 32'(1 << ei.idx));
                    check("cmd_issue", bus.cmd_word, ei.cmd);
                    last_cmd  = ei.cmd;
                    issue_cyc = cyc;
                    if (have_rsp) begin
                        n_checks++;
                        if (cyc - last_rsp_cyc < GUARD + 2) begin
                            n_fail++;
                            $display("FAIL spacing: got %0d cycles, expected >= %0d", cyc - last_rsp_cyc, GUARD + 2);
                        end
                    end
                end
            end else if (bus.cmd_word != '0) begin
                check("cmd_hold", bus.cmd_word, last_cmd);
            end
            if (bus.rsp_valid != '0) begin
                n_rsp_seen++;
                if (exp_rsp.size() == 0) begin
                    fail_now("unexpected_rsp", $sformatf("rsp_valid=%b with nothing outstanding", bus.rsp_valid));
                end else begin
                    er = exp_rsp.pop_front();
                    check("rsp_idx", 32'(bus.rsp_valid), 32'(1 << er.idx));
                    check("rsp_err", 32'(bus.rsp_err), 32'(er.err));
                    check("rsp_rdata", 32'(bus.rsp_rdata), 32'(er.rdata));
                    check("cmd_cleared", bus.cmd_word, 32'h0);
                    if (er.lat >= 0) check("rsp_latency", 32'(cyc - issue_cyc), 32'(er.lat));
                end
                last_rsp_cyc = cyc;
                have_rsp     = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic expect_txn(input int idx, input logic we, input logic [6:0] a,
                              input logic [7:0] d, input bit with_rsp);
        iss_t ei;
        rsp_t er;
        ei.idx = idx;
        ei.cmd = exp_cmd(we, a, d);
        exp_iss.push_back(ei);
        er.idx   = idx;
        er.lat   = -1;
        er.err   = 1'b0;
        er.rdata = 8'h00;
        if (fault_mode == 2) begin
            er.err = 1'b1;
            er.lat = TIMEOUT + 1;
        end else begin
            if (we) ref_mem[a] = d;
            if (fault_mode == 1) er.err = 1'b1;
            else if (!we) er.rdata = ref_mem[a];
        end
        if (with_rsp) exp_rsp.push_back(er);
        lg_model = idx;
    endtask

    task automatic post(input int idx, input logic we, input logic [6:0] a, input logic [7:0] d);
        bus.req_we[idx]          = we;
        bus.req_addr[idx*7 +: 7] = a;
        bus.req_wdata[idx*8 +: 8] = d;
        bus.req_valid[idx]       = 1'b1;
    endtask

    task automatic wait_ready(input int idx, output bit ok);
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.req_ready[idx]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("ready_timeout", $sformatf("req %0d got no req_ready, required within 100 cycles", idx));
    endtask

    task automatic drain();
        for (int t = 0; t < TIMEOUT + 60; t++) begin
            if (exp_iss.size() == 0 && exp_rsp.size() == 0) break;
            @(negedge clk);
        end
        if (exp_iss.size() != 0 || exp_rsp.size() != 0) begin
            fail_now("drain", $sformatf("%0d grants and %0d responses never arrived", exp_iss.size(), exp_rsp.size()));
            exp_iss.delete();
            exp_rsp.delete();
        end
    endtask

    task automatic single(input int idx, input logic we, input logic [6:0] a,
                          input logic [7:0] d, input int mode);
        bit ok;
        fault_mode = mode;
        @(posedge clk); #1;
        expect_txn(idx, we, a, d, 1);
        post(idx, we, a, d);
        wait_ready(idx, ok);
        @(posedge clk); #1;
        bus.req_valid[idx] = 1'b0;
        drain();
    endtask

    // All requesters raise together; a granted one re-posts while more
    // grants are wanted than other requests are still pending.
    task automatic contend(input int n);
        bit [NREQ-1:0] pend;
        logic          we_p[NREQ];
        logic [6:0]    a_p[NREQ];
        logic [7:0]    d_p[NREQ];
        bit            ok;
        int            w;
        fault_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            we_p[i] = 1'($urandom_range(0, 1));
            a_p[i]  = 7'($urandom_range(0, 127));
            d_p[i]  = 8'($urandom);
            post(i, we_p[i], a_p[i], d_p[i]);
        end
        pend = '1;
        for (int k = 0; k < n; k++) begin
            w = pick(pend, lg_model);
            expect_txn(w, we_p[w], a_p[w], d_p[w], 1);
            wait_ready(w, ok);
            @(posedge clk); #1;
            if (!ok) begin
                bus.req_valid = '0;
                break;
            end
            if (n - 1 - k > $countones(pend) - 1) begin
                we_p[w] = 1'($urandom_range(0, 1));
                a_p[w]  = 7'($urandom_range(0, 127));
                d_p[w]  = 8'($urandom);
                post(w, we_p[w], a_p[w], d_p[w]);
            end else begin
                bus.req_valid[w] = 1'b0;
                pend[w] = 1'b0;
            end
        end
        bus.req_valid = '0;
        drain();
    endtask

    initial begin
        bit ok;
        int r, seen_before;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 29 + 7);
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset_cmd_word", bus.cmd_word, 32'h0);
        check("reset_req_ready", 32'(bus.req_ready), 32'h0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
        check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        rst_n = 1'b1;

        single(1, 1'b1, 7'h15, 8'hA5, 0);  // store 0xA5 at 0x15
        single(0, 1'b0, 7'h15, 8'h00, 0);  // read it back, cmd 0x6000_0015
        single(1, 1'b1, 7'h7F, 8'h3C, 0);  // cmd 0x4000_1E7F
        contend(3);                        // grants 0, 1, 0
        single(0, 1'b0, 7'h15, 8'h00, 2);  // silent master: error after TIMEOUT
        single(0, 1'b0, 7'h15, 8'h00, 1);  // master answers for 0x14

        // Reset in the middle of a wait: nothing may answer the aborted command.
        fault_mode = 2;
        @(posedge clk); #1;
        expect_txn(0, 1'b0, 7'h22, 8'h00, 0);
        post(0, 1'b0, 7'h22, 8'h00);
        wait_ready(0, ok);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        seen_before = n_rsp_seen;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_cmd", bus.cmd_word, 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        lg_model = NREQ - 1;
        repeat (TIMEOUT + 5) @(negedge clk);
        check("no_rsp_after_abort", 32'(n_rsp_seen), 32'(seen_before));
        exp_iss.delete();
        contend(2);                        // requester 0 first again

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                contend($urandom_range(2, 4));
            end else begin
                r = $urandom_range(0, 9);
                single($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)),
                       7'($urandom_range(0, 127)), 8'($urandom),
                       (r == 0) ? 2 : (r == 1) ? 1 : 0);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_scheduler.md
# spi_mem_scheduler

Command scheduler that shares the single SPI EEPROM master between `NREQ` requesters. Each requester posts a byte read or byte write, and the scheduler grants requests round-robin. For each granted request it:
- presents one 32-bit command word to the master's command input,
- tracks the master's write-back handshake,
- returns read data or an error to the requester that issued the command.

It sits between the Wishbone-side request logic and the SPI master, in place of a static command buffer.

## Interface

Parameters:
- `NREQ`, 2: number of requesters (2..4).
- `TIMEOUT`, 8192: clk cycles allowed in WAIT before the command is aborted.
- `GUARD`, 4: idle cycles with command word cleared between commands.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: request pending; held until `req_ready` for that index.
- `req_we` in NREQ: 1 = byte write, 0 = byte read.
- `req_addr` in NREQ*7: EEPROM byte address, index i at [7i+6:7i].
- `req_wdata` in NREQ*8: write data, index i at [8i+7:8i].
- `req_ready` out NREQ: one-cycle accept pulse.
- `rsp_valid` out NREQ: one-cycle completion pulse.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 = timeout or address mismatch.
- `rsp_rdata` out 8: read byte, valid with `rsp_valid`; 0 for writes and errors.
- `cmd_word` out 32: to master command input. Fields: [31] ready, [30] busy, [29] R/Wn, [14:7] data, [6:0] address.
- `res_word` in 32: master result word, same field layout.
- `res_we` in 1: master result write strobe.

## Operation

States:
- **IDLE**: `cmd_word` = 0. If any `req_valid` is high, pick the winner round-robin: the search starts at `last_grant+1` and wraps modulo NREQ. Latch `we`, `addr`, `wdata` and the winner index, then go to ISSUE.
- **ISSUE** (1 cycle):
  - `req_ready[winner]` = 1.
  - `cmd_word` = {1'b0, 1'b1, ~we, 14'b0, wdata, addr}; for reads, bits [14:7] = 0.
  - `last_grant` = winner.
  - Clear `seen_we` and the timeout counter; go to WAIT.
- **WAIT**:
  - `cmd_word` is held constant.
  - Set `seen_we` on `res_we` = 1.
  - Completion: `seen_we` && `res_we` = 0 && `res_word[31]` = 1. The master updates its result word only after dropping the strobe, so the strobe alone is not a valid completion.
  - On completion, error = (`res_word[6:0]` != latched addr).
  - Timeout: counter reaches `TIMEOUT`-1 without completion → error.
  - Either case → RESP.
- **RESP** (1 cycle):
  - `rsp_valid[winner]` = 1.
  - `rsp_err` as determined in WAIT.
  - `rsp_rdata` = `res_word[14:7]` for a read without error, else 0.
  - `cmd_word` = 0 (busy dropped, so the master returns to idle); go to GUARD.
- **GUARD**: `cmd_word` = 0 for `GUARD` cycles, then IDLE. This guarantees the master samples busy = 0 on at least one of its rise phases before the next command.

Rules:
- Requests arriving in any non-IDLE state wait; `req_valid` must stay high until accepted. Dropping it early is legal and means the request is withdrawn.
- Simultaneous `req_valid`: round-robin winner only; the others are untouched.
- `last_grant` resets to NREQ-1, so requester 0 wins the first contention.
- A timeout does not reset the master. The master stops because busy is dropped in RESP/GUARD.
- Reset mid-operation:
  - All state returns to IDLE.
  - `cmd_word` = 0 immediately (asynchronous).
  - No `rsp_valid` is generated for the aborted command.

## Timing

- Reset values: `cmd_word` = 0, `req_ready` = 0, `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, state IDLE, `last_grant` = NREQ-1, counters 0.
- All outputs are registered.
- `req_valid` sampled high in IDLE at cycle N → `req_ready` and `cmd_word` valid in cycle N+1.
- Completion condition true at cycle M → `rsp_valid` in cycle M+1, `cmd_word` = 0 from M+1.
- Minimum spacing from `rsp_valid` to the next `req_ready`: GUARD+2 cycles.
- Timeout counter: ceil(log2(TIMEOUT)) bits, saturating, cleared in ISSUE.

## Structure

- Package `spi_mem_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP, GUARD);
  - field constants `CMD_READY`=31, `CMD_BUSY`=30, `CMD_RWN`=29, `CMD_DATA_LSB`=7, `CMD_ADDR_W`=7;
  - function `mk_cmd(we, addr, wdata)`.
- Sub-module `rr_arbiter`: parameterised `NREQ` round-robin picker. Inputs are the request vector and `last_grant`; outputs are the one-hot grant and its index. Purely combinational; the pointer is kept in the scheduler.

## Test plan

- **Single read:** req0 read addr 0x15. Model sets `res_we` high 2 cycles, then `res_word` = {1, 0x…, 8'hA5 @[14:7], 0x15}. Expect `rsp_valid[0]`, `rsp_rdata` = 0xA5, `rsp_err` = 0, `cmd_word` = 0x6000_0015 during WAIT.
- **Write encoding:** req1 write addr 0x7F, data 0x3C. Expect `cmd_word` = 0x4000_1E7F. On completion `rsp_valid[1]`, `rsp_rdata` = 0.
- **Contention:** req0 and req1 high together, three times. Expect grant order 0, 1, 0, with ≥ GUARD+2 cycles between `rsp_valid` and the next `req_ready`.
- **Timeout:** `res_we` never asserted, TIMEOUT = 16. Expect `rsp_err` = 1 in cycle ISSUE+17, then `cmd_word` = 0.
- **Address mismatch:** result address 0x14 for issued 0x15. Expect `rsp_err` = 1, `rsp_rdata` = 0.
- **Reset mid-WAIT:** assert `rst_n` low. Expect `cmd_word` = 0 asynchronously, no `rsp_valid`, and requester 0 granted first after release.
